// File: rtl/reg_bank.sv
// reg_bank: 2-read/1-write register bank with registered, write-first reads, r0 tied to zero, and a clear sequencer after reset
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK_RB,
  input  logic              RSTN_RB,
  input  logic [ADDR_W-1:0] AR1_RB,
  input  logic [ADDR_W-1:0] AR2_RB,
  input  logic [ADDR_W-1:0] AW_RB,
  input  logic [DATA_W-1:0] DW_RB,
  input  logic              WE_RB,
  output logic [DATA_W-1:0] DR1_RB,
  output logic [DATA_W-1:0] DR2_RB,
  output logic              BUSY_RB
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dr1_nx, dr2_nx;
  logic busy;
  assign busy    = (state == CLEAR);
  assign BUSY_RB = busy;
  assign dr1_nx  = (busy || AR1_RB == '0) ? '0 : (WE_RB && AW_RB == AR1_RB) ? DW_RB : mem[AR1_RB];
  assign dr2_nx  = (busy || AR2_RB == '0) ? '0 : (WE_RB && AW_RB == AR2_RB) ? DW_RB : mem[AR2_RB];
  // sequencer sweeps every address once, then hands over to RUN for good
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (busy) begin
      cnt_nx   = cnt + 1'b1;
      state_nx = (cnt == '1) ? RUN : CLEAR;
    end
  end
  // state, sweep counter and read registers; reset restarts the sweep
  always_ff @(posedge CLK_RB or negedge RSTN_RB) begin
    if (!RSTN_RB) begin
      state  <= CLEAR;
      cnt    <= '0;
      DR1_RB <= '0;
      DR2_RB <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      DR1_RB <= dr1_nx;
      DR2_RB <= dr2_nx;
    end
  end
  // array: cleared by the sweep, otherwise written by the port except at r0
  always_ff @(posedge CLK_RB) begin
    if (busy)
      mem[cnt] <= '0;
    else if (WE_RB && AW_RB != '0)
      mem[AW_RB] <= DW_RB;
  end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table vectors, corner sequences and random traffic against an array model
module tb_reg_bank;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ar1 = '0, ar2 = '0, aw = '0;
  logic [DW-1:0] dw = '0;
  logic          we = 1'b0;
  logic [DW-1:0] dr1, dr2;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] model [N];

  typedef struct {
    logic          we;
    logic [AW-1:0] aw;
    logic [DW-1:0] dw;
    logic [AW-1:0] ar1;
    logic [AW-1:0] ar2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;
  vec_t tbl [8];

  reg_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK_RB(clk), .RSTN_RB(rst_n),
    .AR1_RB(ar1), .AR2_RB(ar2), .AW_RB(aw), .DW_RB(dw), .WE_RB(we),
    .DR1_RB(dr1), .DR2_RB(dr2), .BUSY_RB(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic w, input logic [AW-1:0] a,
                                               input logic [DW-1:0] d, input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (w && a == r) return d;
    return model[r];
  endfunction

  // one RUN-mode cycle checked against the model
  task automatic run_step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [AW-1:0] r1, input logic [AW-1:0] r2, input string tag);
    logic [DW-1:0] e1, e2;
    we = w; aw = a; dw = d; ar1 = r1; ar2 = r2;
    e1 = expect_rd(w, a, d, r1);
    e2 = expect_rd(w, a, d, r2);
    @(posedge clk); #1;
    if (w && a != 0) model[a] = d;
    check({tag, " dr1"}, dr1, e1);
    check({tag, " dr2"}, dr2, e2);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
  endtask

  // 32 edges of clear; optionally try a write to r3 at edge 10
  task automatic wait_clear(input bit inject, input string tag);
    for (int i = 1; i <= N; i++) begin
      if (inject && i == 10) begin we = 1'b1; aw = 5'd3; dw = 32'hAAAA5555; end
      @(posedge clk); #1;
      we = 1'b0;
      check($sformatf("%s busy@%0d", tag, i), {31'b0, busy}, (i < N) ? 32'd1 : 32'd0);
      if (i < N) check($sformatf("%s dr1@%0d", tag, i), dr1, 32'd0);
    end
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // reset pulse mid-cycle; outputs must react without a clock edge
  task automatic pulse_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check({tag, " async dr1"}, dr1, 32'd0);
    check({tag, " async dr2"}, dr2, 32'd0);
    check({tag, " async busy"}, {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd9,  32'h00000007, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  32'hDEADBEEF, 32'h00000007};
    tbl[3] = '{1'b1, 5'd12, 32'h12345678, 5'd12, 5'd12, 32'h12345678, 32'h12345678};
    tbl[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd12, 32'h0,        32'h12345678};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    tbl[6] = '{1'b1, 5'd5,  32'h0,        5'd5,  5'd9,  32'h0,        32'h00000007};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0};

    repeat (2) @(posedge clk);
    #1;
    check("init busy", {31'b0, busy}, 32'd1);
    check("init dr1", dr1, 32'd0);
    #4 rst_n = 1'b1;
    wait_clear(1'b0, "clr0");

    for (int i = 0; i < 8; i++) begin
      we = tbl[i].we; aw = tbl[i].aw; dw = tbl[i].dw; ar1 = tbl[i].ar1; ar2 = tbl[i].ar2;
      @(posedge clk); #1;
      if (tbl[i].we && tbl[i].aw != 0) model[tbl[i].aw] = tbl[i].dw;
      check($sformatf("vec%0d dr1", i), dr1, tbl[i].e1);
      check($sformatf("vec%0d dr2", i), dr2, tbl[i].e2);
    end

    for (int i = 0; i < 300; i++)
      run_step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), "rnd");

    for (int i = 1; i < N; i++) run_step(1'b1, 5'(i), $urandom | 32'h1, 5'(i), 5'(0), "garbage");
    run_step(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, "pre-rst");
    pulse_reset("rst1");
    wait_clear(1'b1, "clr1");
    for (int i = 0; i < N; i++) run_step(1'b0, 5'd0, 32'h0, 5'(i), 5'(N - 1 - i), "swept");
    run_step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "r3 ignored");

    run_step(1'b1, 5'd4, 32'h55, 5'd0, 5'd0, "w r4");
    run_step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "rd r4");
    check("rd r4 literal", dr1, 32'h55);
    pulse_reset("rst2");
    wait_clear(1'b0, "clr2");
    run_step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "r4 cleared");
    check("r4 cleared literal", dr1, 32'h0);

    for (int i = 0; i < 100; i++)
      run_step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rnd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
# reg_bank

Two-read/one-write general-purpose register bank for the Jericalla datapath, sitting directly upstream of the ALU. Its two read ports supply the ALU's first and second operands, and its write port takes the ALU result or load data back. Reads are registered, with one cycle of latency and write-first bypass. Register 0 is hard-wired to zero. After every reset, an internal sequencer clears the whole array before the bank accepts traffic.

## Interface
- DATA_W, 32, data width of each register and of all data ports
- ADDR_W, 5, address width; depth = 2^ADDR_W registers (32 by default)
- CLK_RB  input  1  clock; all state updates on the rising edge
- RSTN_RB  input  1  reset, asynchronous and active-low
- AR1_RB  input  ADDR_W  read address, port 1 (feeds ALU operand 1)
- AR2_RB  input  ADDR_W  read address, port 2 (feeds ALU operand 2)
- AW_RB  input  ADDR_W  write address
- DW_RB  input  DATA_W  write data (ALU result or load data)
- WE_RB  input  1  write enable
- DR1_RB  output  DATA_W  registered read data, port 1
- DR2_RB  output  DATA_W  registered read data, port 2
- BUSY_RB  output  1  high while the clear sequencer runs; traffic is ignored

## Operation
- **Reset:** RSTN_RB low asynchronously forces:
  - DR1_RB = 0, DR2_RB = 0, BUSY_RB = 1
  - state = CLEAR, clear counter = 0
  - Array contents are not reset directly; the sequencer clears them.
- **State CLEAR:**
  - Each cycle, the sequencer writes 0 to reg[counter] and increments the counter.
  - WE_RB is ignored, and DR1_RB/DR2_RB are loaded with 0 every cycle.
  - When counter = 2^ADDR_W−1, that final clear is written and the next state is RUN. The counter wraps to 0 and is unused in RUN.
- **State RUN:**
  - BUSY_RB = 0.
  - Write: if WE_RB = 1 and AW_RB ≠ 0, then reg[AW_RB] ← DW_RB at the clock edge. A write to address 0 is discarded.
  - Read port n, registered each edge:
    - DRn_RB ← 0 if ARn_RB = 0.
    - Otherwise DRn_RB ← DW_RB if WE_RB = 1 and AW_RB = ARn_RB (write-first bypass).
    - Otherwise DRn_RB ← reg[ARn_RB].
  - Both ports are independent; AR1_RB = AR2_RB is legal, and both return the same value.
- RUN is left only by reset. Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from counter 0, and any write in flight is lost.
- No arithmetic on data; values are stored and returned bit-exact at DATA_W.

## Timing
- Read latency: 1 cycle. The address is presented before edge N, and data is valid after edge N. Data is stable for the full following cycle, so the ALU, which is combinational, sees it within that cycle.
- Write latency: 1 cycle. Data written at edge N is visible through the array for reads sampled at edge N+1. A same-edge read gets it through the bypass.
- Clear duration: exactly 2^ADDR_W rising edges after reset release (32 by default).
  - BUSY_RB falls after edge 32.
  - The first accepted write is at edge 33.
- Simultaneous read and write of the same address in RUN: the read returns the new data (DW_RB).
- Simultaneous write to address 0 and read of address 0: the read returns 0.

## Test plan
- **Reset and clear:** pre-load garbage, then pulse RSTN_RB low mid-cycle.
  - Outputs go to 0 and BUSY_RB to 1 immediately, without waiting for a clock edge.
  - BUSY_RB stays 1 for 32 edges.
  - Afterwards, reads of every address 0–31 return 0x00000000.
- **Basic write/read:** write 0xDEADBEEF to r5 and 0x00000007 to r9, then read AR1 = 5, AR2 = 9 → one cycle later DR1 = 0xDEADBEEF, DR2 = 0x00000007.
- **Bypass:** on the same edge, WE = 1, AW = 12, DW = 0x12345678 with AR1 = AR2 = 12 → after that edge, both ports read 0x12345678.
- **Register zero:** write 0xFFFFFFFF to r0 with AR1 = 0 on the same edge, then read r0 again → 0 both times.
- **Writes during CLEAR:** assert WE = 1, AW = 3, DW = 0xAAAA5555 at edge 10 of the sweep → the write is ignored, and r3 reads 0 after BUSY_RB falls.
- **Reset mid-operation:** write r4 = 0x55, then assert reset during RUN → BUSY_RB = 1 for another 32 edges, and r4 reads 0 afterwards.
